// File: rtl/bus_cycle_arbiter.sv
// Two-requester bus cycle arbiter: round-robin grant, then a T1/T2/TW*/T3/T4
// strobe sequence toward a single memory/IO device with registered outputs.
module bus_cycle_arbiter #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  REQ,
    input  logic [1:0]  WE,
    input  logic [1:0]  IOM_IN,
    input  logic [19:0] ADDR0,
    input  logic [19:0] ADDR1,
    input  logic [7:0]  WDATA0,
    input  logic [7:0]  WDATA1,
    input  logic [7:0]  DataIn,
    output logic [1:0]  GNT,
    output logic [1:0]  DONE,
    output logic [7:0]  RDATA,
    output logic        ALE,
    output logic        IOM,
    output logic        RD,
    output logic        WR,
    output logic [19:0] Address,
    output logic [7:0]  DataOut,
    output logic        DataOE,
    output logic        BUSY
);

    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned WS_LAST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TW,
        S_T3,
        S_T4
    } state_t;

    state_t              state;
    state_t              nxt_state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    nxt_cnt;
    logic                last_q;
    logic                nxt_last;
    logic                we_q;
    logic                nxt_we;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   nxt_wdata;
    logic [ADDR_W-1:0]   nxt_addr;
    logic                nxt_iom;
    logic [1:0]          nxt_gnt;
    logic [1:0]          nxt_done;
    logic                nxt_ale;
    logic                nxt_rd;
    logic                nxt_wr;
    logic                nxt_oe;
    logic [DATA_W-1:0]   nxt_dout;
    logic                nxt_busy;
    logic                take;
    logic                win;
    logic                strobe;

    // Next state, arbitration and next-cycle output values
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_last  = last_q;
        nxt_gnt   = GNT;
        nxt_we    = we_q;
        nxt_wdata = wdata_q;
        nxt_addr  = Address;
        nxt_iom   = IOM;
        take      = 1'b0;
        // On a tie the requester that did not own the previous cycle wins
        win       = (REQ == 2'b11) ? ~last_q : REQ[1];

        case (state)
            S_IDLE: begin
                if (|REQ) begin
                    take = 1'b1;
                end
            end
            S_T1: begin
                nxt_state = S_T2;
            end
            S_T2: begin
                nxt_cnt   = '0;
                nxt_state = (WAIT_STATES > 0) ? S_TW : S_T3;
            end
            S_TW: begin
                if (cnt == CNT_W'(WS_LAST)) begin
                    nxt_state = S_T3;
                end else begin
                    nxt_cnt = cnt + 3'd1;
                end
            end
            S_T3: begin
                nxt_state = S_T4;
            end
            S_T4: begin
                if (|REQ) begin
                    take = 1'b1;
                end else begin
                    nxt_state = S_IDLE;
                    nxt_gnt   = 2'b00;
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_gnt   = 2'b00;
            end
        endcase

        if (take) begin
            nxt_state = S_T1;
            nxt_gnt   = win ? 2'b10 : 2'b01;
            nxt_last  = win;
            nxt_we    = WE[win];
            nxt_iom   = IOM_IN[win];
            nxt_addr  = win ? ADDR1 : ADDR0;
            nxt_wdata = win ? WDATA1 : WDATA0;
        end

        strobe   = (nxt_state == S_T2) || (nxt_state == S_TW) || (nxt_state == S_T3);
        nxt_ale  = (nxt_state == S_T1);
        nxt_rd   = ~(strobe & ~nxt_we);
        nxt_wr   = ~(strobe & nxt_we);
        nxt_oe   = strobe & nxt_we;
        nxt_dout = nxt_oe ? nxt_wdata : '0;
        nxt_done = (nxt_state == S_T4) ? nxt_gnt : 2'b00;
        nxt_busy = (nxt_state != S_IDLE);
    end

    // State, latched cycle attributes and registered outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state   <= S_IDLE;
            cnt     <= '0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            wdata_q <= '0;
            GNT     <= 2'b00;
            DONE    <= 2'b00;
            RDATA   <= '0;
            ALE     <= 1'b0;
            IOM     <= 1'b0;
            RD      <= 1'b1;
            WR      <= 1'b1;
            Address <= '0;
            DataOut <= '0;
            DataOE  <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            last_q  <= nxt_last;
            we_q    <= nxt_we;
            wdata_q <= nxt_wdata;
            GNT     <= nxt_gnt;
            DONE    <= nxt_done;
            ALE     <= nxt_ale;
            IOM     <= nxt_iom;
            RD      <= nxt_rd;
            WR      <= nxt_wr;
            Address <= nxt_addr;
            DataOut <= nxt_dout;
            DataOE  <= nxt_oe;
            BUSY    <= nxt_busy;
            if (state == S_T3 && !we_q) begin
                RDATA <= DataIn;
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Scoreboard bench for bus_cycle_arbiter: one instance with one wait state,
// one with none; a monitor per instance checks each completed bus cycle.
module tb_bus_cycle_arbiter;

    typedef struct packed {
        logic [1:0]  owner;
        logic [19:0] addr;
        logic        iom;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        b2b;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_n  [2];
    logic [1:0]  req    [2];
    logic [1:0]  we_i   [2];
    logic [1:0]  iom_i  [2];
    logic [19:0] a0     [2];
    logic [19:0] a1     [2];
    logic [7:0]  wd0    [2];
    logic [7:0]  wd1    [2];
    logic [7:0]  din    [2];
    logic [1:0]  gnt    [2];
    logic [1:0]  done   [2];
    logic [7:0]  rdata  [2];
    logic        ale    [2];
    logic        iom    [2];
    logic        rd     [2];
    logic        wr     [2];
    logic [19:0] addr_o [2];
    logic [7:0]  dout   [2];
    logic        oe     [2];
    logic        busy   [2];

    int   errors = 0;
    int   checks = 0;
    int   done_cnt [2];
    logic [7:0] rdata_m [2];
    exp_t q0[$];
    exp_t q1[$];

    bus_cycle_arbiter #(.WAIT_STATES(1)) u_dut_ws1 (
        .CLK(CLK), .RESET(rst_n[0]), .REQ(req[0]), .WE(we_i[0]), .IOM_IN(iom_i[0]),
        .ADDR0(a0[0]), .ADDR1(a1[0]), .WDATA0(wd0[0]), .WDATA1(wd1[0]), .DataIn(din[0]),
        .GNT(gnt[0]), .DONE(done[0]), .RDATA(rdata[0]), .ALE(ale[0]), .IOM(iom[0]),
        .RD(rd[0]), .WR(wr[0]), .Address(addr_o[0]), .DataOut(dout[0]),
        .DataOE(oe[0]), .BUSY(busy[0])
    );

    bus_cycle_arbiter #(.WAIT_STATES(0)) u_dut_ws0 (
        .CLK(CLK), .RESET(rst_n[1]), .REQ(req[1]), .WE(we_i[1]), .IOM_IN(iom_i[1]),
        .ADDR0(a0[1]), .ADDR1(a1[1]), .WDATA0(wd0[1]), .WDATA1(wd1[1]), .DataIn(din[1]),
        .GNT(gnt[1]), .DONE(done[1]), .RDATA(rdata[1]), .ALE(ale[1]), .IOM(iom[1]),
        .RD(rd[1]), .WR(wr[1]), .Address(addr_o[1]), .DataOut(dout[1]),
        .DataOE(oe[1]), .BUSY(busy[1])
    );

    function automatic int unsigned ws_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Per-cycle protocol checks plus one scoreboard pop per DONE pulse
    task automatic monitor(input int k);
        logic        active = 1'b0;
        logic        prev_ale = 1'b0;
        logic        addr_var = 1'b0;
        logic        dout_var = 1'b0;
        logic [19:0] a_t1 = '0;
        logic [7:0]  dout_seen = '0;
        int          cyc = 0, rd_lo = 0, wr_lo = 0, oe_n = 0, gap = 0, gap_at_ale = 0;
        int unsigned ws;
        int          qsz;
        exp_t        e;
        ws = ws_of(k);
        forever begin
            @(negedge CLK);
            chk("strobe_overlap", 32'(!rd[k] && !wr[k]), 32'(0));
            if (ale[k]) begin
                chk("ale_only_t1", 32'({prev_ale, rd[k], wr[k], oe[k]}), 32'(4'b0110));
                chk("done_per_cycle", 32'(active), 32'(0));
                active = 1'b1; cyc = 1; rd_lo = 0; wr_lo = 0; oe_n = 0;
                a_t1 = addr_o[k]; addr_var = 1'b0; dout_var = 1'b0; dout_seen = '0;
                gap_at_ale = gap;
            end else if (active) begin
                cyc++;
                if (!rd[k]) rd_lo++;
                if (!wr[k]) wr_lo++;
                if (oe[k]) begin
                    if (oe_n > 0 && dout[k] !== dout_seen) dout_var = 1'b1;
                    dout_seen = dout[k];
                    oe_n++;
                end
                if (addr_o[k] !== a_t1) addr_var = 1'b1;
            end
            prev_ale = ale[k];
            if (!busy[k]) begin
                active = 1'b0;
                gap++;
            end
            if (done[k] != 2'b00) begin
                qsz = (k == 0) ? q0.size() : q1.size();
                if (qsz == 0) begin
                    chk("unexpected_done", 32'(done[k]), 32'(0));
                end else begin
                    if (k == 0) e = q0.pop_front();
                    else e = q1.pop_front();
                    chk("done_owner", 32'(done[k]), 32'(e.owner));
                    chk("gnt_owner", 32'(gnt[k]), 32'(e.owner));
                    chk("address", 32'(addr_o[k]), 32'(e.addr));
                    chk("address_stable", 32'(addr_var), 32'(0));
                    chk("iom", 32'(iom[k]), 32'(e.iom));
                    chk("cycle_len", 32'(cyc), 32'(4 + ws));
                    chk("rd_low_cycles", 32'(rd_lo), e.we ? 32'(0) : 32'(2 + ws));
                    chk("wr_low_cycles", 32'(wr_lo), e.we ? 32'(2 + ws) : 32'(0));
                    chk("oe_cycles", 32'(oe_n), e.we ? 32'(2 + ws) : 32'(0));
                    chk("dataout", 32'({dout_var, dout_seen}),
                        32'({1'b0, (e.we ? e.wdata : 8'h00)}));
                    chk("rdata", 32'(rdata[k]), 32'(e.rdata));
                    if (e.b2b) chk("back_to_back_gap", 32'(gap_at_ale), 32'(0));
                end
                active = 1'b0;
                gap = 0;
                done_cnt[k]++;
            end
        end
    endtask

    task automatic wait_done(input int k, input int target);
        int n = 0;
        while (done_cnt[k] < target && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("done_timeout", 32'(done_cnt[k] >= target), 32'(1));
    endtask

    task automatic check_reset(input int k);
        chk("rst_ale", 32'(ale[k]), 32'(0));
        chk("rst_rd", 32'(rd[k]), 32'(1));
        chk("rst_wr", 32'(wr[k]), 32'(1));
        chk("rst_iom", 32'(iom[k]), 32'(0));
        chk("rst_address", 32'(addr_o[k]), 32'(0));
        chk("rst_dataout", 32'(dout[k]), 32'(0));
        chk("rst_dataoe", 32'(oe[k]), 32'(0));
        chk("rst_gnt", 32'(gnt[k]), 32'(0));
        chk("rst_done", 32'(done[k]), 32'(0));
        chk("rst_rdata", 32'(rdata[k]), 32'(0));
        chk("rst_busy", 32'(busy[k]), 32'(0));
    endtask

    task automatic set_attr(input int k, input int who, input logic we, input logic io,
                            input logic [19:0] addr, input logic [7:0] wdata);
        we_i[k][who]  = we;
        iom_i[k][who] = io;
        if (who == 0) begin
            a0[k] = addr; wd0[k] = wdata;
        end else begin
            a1[k] = addr; wd1[k] = wdata;
        end
    endtask

    // Single isolated cycle; inputs are scrambled once the grant is taken
    task automatic run_one(input int k, input int who, input logic we, input logic io,
                           input logic [19:0] addr, input logic [7:0] wdata,
                           input logic [7:0] dval);
        exp_t e;
        int   start;
        set_attr(k, who, we, io, addr, wdata);
        din[k] = dval;
        if (!we) rdata_m[k] = dval;
        e.owner = (who == 0) ? 2'b01 : 2'b10;
        e.addr = addr; e.iom = io; e.we = we; e.wdata = wdata;
        e.rdata = rdata_m[k]; e.b2b = 1'b0;
        push_exp(k, e);
        start = done_cnt[k];
        req[k] = (who == 0) ? 2'b01 : 2'b10;
        @(negedge CLK);
        req[k] = 2'b00;
        a0[k] = ~a0[k]; a1[k] = ~a1[k]; wd0[k] = ~wd0[k]; wd1[k] = ~wd1[k];
        we_i[k] = ~we_i[k]; iom_i[k] = ~iom_i[k];
        wait_done(k, start + 1);
        @(negedge CLK);
    endtask

    // Both requesters held from reset: read by 0, write by 1, alternating
    task automatic contention(input int k, input int n);
        exp_t e;
        int   start;
        rst_n[k] = 1'b0;
        set_attr(k, 0, 1'b0, 1'b1, 20'h11111, 8'h00);
        set_attr(k, 1, 1'b1, 1'b0, 20'h22222, 8'h99);
        din[k] = 8'h77;
        req[k] = 2'b11;
        @(negedge CLK);
        rst_n[k] = 1'b1;
        rdata_m[k] = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) begin
                rdata_m[k] = 8'h77;
                e.owner = 2'b01; e.addr = 20'h11111; e.iom = 1'b1; e.we = 1'b0; e.wdata = 8'h00;
            end else begin
                e.owner = 2'b10; e.addr = 20'h22222; e.iom = 1'b0; e.we = 1'b1; e.wdata = 8'h99;
            end
            e.rdata = rdata_m[k];
            e.b2b = (i > 0);
            push_exp(k, e);
        end
        start = done_cnt[k];
        wait_done(k, start + n - 1);
        @(negedge CLK);
        req[k] = 2'b00;
        wait_done(k, start + n);
        @(negedge CLK);
    endtask

    // Reset during TW abandons the cycle with no DONE
    task automatic reset_mid(input int k);
        set_attr(k, 0, 1'b0, 1'b0, 20'h0BEEF, 8'h00);
        din[k] = 8'h42;
        req[k] = 2'b01;
        @(negedge CLK);
        req[k] = 2'b00;
        @(negedge CLK);
        @(negedge CLK);
        chk("mid_cycle_rd_low", 32'(rd[k]), 32'(0));
        rst_n[k] = 1'b0;
        @(negedge CLK);
        chk("abort_rd", 32'(rd[k]), 32'(1));
        chk("abort_wr", 32'(wr[k]), 32'(1));
        chk("abort_busy", 32'(busy[k]), 32'(0));
        chk("abort_gnt", 32'(gnt[k]), 32'(0));
        chk("abort_done", 32'(done[k]), 32'(0));
        rst_n[k] = 1'b1;
        rdata_m[k] = 8'h00;
        repeat (8) @(negedge CLK);
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req[k] = '0; we_i[k] = '0; iom_i[k] = '0;
            a0[k] = '0; a1[k] = '0; wd0[k] = '0; wd1[k] = '0; din[k] = '0;
            rdata_m[k] = '0; done_cnt[k] = 0;
        end
        repeat (3) @(negedge CLK);
        check_reset(0);
        check_reset(1);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge CLK);

        run_one(0, 0, 1'b0, 1'b1, 20'h12345, 8'h00, 8'hA5);
        run_one(0, 1, 1'b1, 1'b0, 20'h0ABCD, 8'h5A, 8'h11);
        run_one(0, 1, 1'b0, 1'b1, 20'h54321, 8'h00, 8'hC3);
        contention(0, 4);
        reset_mid(0);
        run_one(0, 0, 1'b1, 1'b1, 20'hFFFFF, 8'hFF, 8'h00);

        run_one(1, 1, 1'b1, 1'b0, 20'h0F0F0, 8'h3C, 8'h00);
        run_one(1, 0, 1'b0, 1'b0, 20'h00001, 8'h00, 8'h96);
        contention(1, 4);

        repeat (5) @(negedge CLK);
        chk("pending_exp_ws1", 32'(q0.size()), 32'(0));
        chk("pending_exp_ws0", 32'(q1.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
